// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared constants and saturation helper for the Costas loop filter
package costas_pkg;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    localparam int IN_W_DEF        = 12;
    localparam int ACC_LOG2_DEF    = 4;
    localparam int INT_W_DEF       = 20;
    localparam int LOCK_THRESH_DEF = 64;
    localparam int OUT_W           = 16;

    // Clamp x into a w-bit signed range; sym drops the most negative code.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] x,
        input int unsigned        w,
        input logic               sym
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = sym ? -hi : -hi - 32'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/costas_phase_detector.sv
// rtl/costas_phase_detector.sv - registered BPSK/QPSK Costas phase error
module costas_phase_detector
    import costas_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic signed [IN_W-1:0] sample_i,
    input  logic signed [IN_W-1:0] sample_q,
    input  logic                   sample_valid,
    input  logic                   mode,
    output logic signed [IN_W:0]   e,
    output logic                   e_valid
);

    logic signed [IN_W:0] i_ext;
    logic signed [IN_W:0] q_ext;
    logic signed [IN_W:0] term_q;
    logic signed [IN_W:0] term_i;
    logic signed [IN_W:0] e_next;

    assign i_ext = {sample_i[IN_W-1], sample_i};
    assign q_ext = {sample_q[IN_W-1], sample_q};

    // sgn() multiplies as negate/select; zero counts as positive.
    assign term_q = sample_i[IN_W-1] ? -q_ext : q_ext;
    assign term_i = sample_q[IN_W-1] ? -i_ext : i_ext;
    assign e_next = (mode == MODE_QPSK) ? (term_q - term_i) : term_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            e       <= '0;
            e_valid <= 1'b0;
        end else begin
            e_valid <= sample_valid;
            if (sample_valid)
                e <= e_next;
        end
    end

endmodule

// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - Costas error, integrate-and-dump and shift-gain PI loop filter
module costas_loop_filter
    import costas_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int ACC_LOG2    = ACC_LOG2_DEF,
    parameter int INT_W       = INT_W_DEF,
    parameter int LOCK_THRESH = LOCK_THRESH_DEF
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic signed [IN_W-1:0]  baseband_I,
    input  logic signed [IN_W-1:0]  baseband_Q,
    input  logic                    baseband_valid,
    input  logic                    MODE,
    input  logic [1:0]              KP_SHIFT,
    input  logic [3:0]              KI_SHIFT,
    input  logic                    loop_clear,
    output logic signed [OUT_W-1:0] feedback_tdata,
    output logic                    feedback_tvalid,
    output logic                    locked
);

    localparam int ACC_W = IN_W + 1 + ACC_LOG2;
    localparam int AVG_W = IN_W + 1;

    // Input capture; MODE is frozen on the first sample of each window.
    logic signed [IN_W-1:0] in_i;
    logic signed [IN_W-1:0] in_q;
    logic                   in_valid;
    logic                   in_mode;
    logic                   mode_hold;
    logic [ACC_LOG2-1:0]    samp_cnt;
    logic                   mode_now;

    assign mode_now = (samp_cnt == '0) ? MODE : mode_hold;

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            in_i      <= '0;
            in_q      <= '0;
            in_valid  <= 1'b0;
            in_mode   <= MODE_BPSK;
            mode_hold <= MODE_BPSK;
            samp_cnt  <= '0;
        end else if (loop_clear) begin
            in_valid  <= 1'b0;
            samp_cnt  <= '0;
        end else begin
            in_valid <= baseband_valid;
            if (baseband_valid) begin
                in_i     <= baseband_I;
                in_q     <= baseband_Q;
                in_mode  <= mode_now;
                samp_cnt <= samp_cnt + 1'b1;
                if (samp_cnt == '0)
                    mode_hold <= MODE;
            end
        end
    end

    logic signed [IN_W:0] e;
    logic                 e_valid;

    costas_phase_detector #(.IN_W(IN_W)) u_pd (
        .clk          (clk_16M384),
        .rst          (rst_16M384),
        .clear        (loop_clear),
        .sample_i     (in_i),
        .sample_q     (in_q),
        .sample_valid (in_valid),
        .mode         (in_mode),
        .e            (e),
        .e_valid      (e_valid)
    );

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [AVG_W-1:0] avg;
    logic                    avg_valid;
    logic [ACC_LOG2-1:0]     win_cnt;
    logic signed [INT_W-1:0] integ;
    logic signed [INT_W-1:0] integ_new;
    logic [3:0]              lock_cnt;
    logic [3:0]              lock_next;

    logic signed [31:0] avg_ext;
    logic signed [31:0] integ_sum;
    logic signed [31:0] integ_new_ext;
    logic signed [31:0] integ_shr;
    logic signed [31:0] prop;
    logic               in_lock;

    assign acc_sum = acc + {{ACC_LOG2{e[IN_W]}}, e};

    assign avg_ext       = {{(32-AVG_W){avg[AVG_W-1]}}, avg};
    assign integ_sum     = {{(32-INT_W){integ[INT_W-1]}}, integ} + avg_ext;
    assign integ_new     = INT_W'(sat_signed(integ_sum, INT_W, 1'b1));
    assign integ_new_ext = {{(32-INT_W){integ_new[INT_W-1]}}, integ_new};
    assign integ_shr     = integ_new_ext >>> KI_SHIFT;
    assign prop          = avg_ext <<< KP_SHIFT;

    assign in_lock   = (avg_ext < LOCK_THRESH) && (avg_ext > -LOCK_THRESH);
    assign lock_next = in_lock ? ((lock_cnt == 4'hF) ? 4'hF : lock_cnt + 4'h1)
                               : ((lock_cnt == 4'h0) ? 4'h0 : lock_cnt - 4'h1);

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            acc             <= '0;
            win_cnt         <= '0;
            avg             <= '0;
            avg_valid       <= 1'b0;
            integ           <= '0;
            lock_cnt        <= '0;
            locked          <= 1'b0;
            feedback_tdata  <= '0;
            feedback_tvalid <= 1'b0;
        end else if (loop_clear) begin
            // Clear beats any dump or PI update on the same edge; the last word stays on the bus.
            acc             <= '0;
            win_cnt         <= '0;
            avg_valid       <= 1'b0;
            integ           <= '0;
            lock_cnt        <= '0;
            locked          <= 1'b0;
            feedback_tvalid <= 1'b0;
        end else begin
            avg_valid       <= 1'b0;
            feedback_tvalid <= 1'b0;
            if (e_valid) begin
                if (&win_cnt) begin
                    avg       <= acc_sum[ACC_W-1:ACC_LOG2];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    win_cnt   <= '0;
                end else begin
                    acc     <= acc_sum;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
            if (avg_valid) begin
                integ           <= integ_new;
                feedback_tdata  <= OUT_W'(sat_signed(prop + integ_shr, OUT_W, 1'b0));
                feedback_tvalid <= 1'b1;
                lock_cnt        <= lock_next;
                if (lock_next == 4'hF)
                    locked <= 1'b1;
                else if (lock_next == 4'h0)
                    locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_costas_loop_filter.sv
// tb/tb_costas_loop_filter.sv - randomized self-checking bench with window-level reference model
module tb_costas_loop_filter;

    logic               clk_16M384 = 1'b0;
    logic               rst_16M384;
    logic signed [11:0] baseband_I;
    logic signed [11:0] baseband_Q;
    logic               baseband_valid;
    logic               MODE;
    logic [1:0]         KP_SHIFT;
    logic [3:0]         KI_SHIFT;
    logic               loop_clear;
    logic signed [15:0] feedback_tdata;
    logic               feedback_tvalid;
    logic               locked;

    costas_loop_filter dut (
        .clk_16M384      (clk_16M384),
        .rst_16M384      (rst_16M384),
        .baseband_I      (baseband_I),
        .baseband_Q      (baseband_Q),
        .baseband_valid  (baseband_valid),
        .MODE            (MODE),
        .KP_SHIFT        (KP_SHIFT),
        .KI_SHIFT        (KI_SHIFT),
        .loop_clear      (loop_clear),
        .feedback_tdata  (feedback_tdata),
        .feedback_tvalid (feedback_tvalid),
        .locked          (locked)
    );

    always #5 clk_16M384 = ~clk_16M384;

    longint cyc = 0;
    always @(posedge clk_16M384) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int     data;
        int     lk;
        longint at;
    } strobe_t;

    strobe_t expq[$];

    int m_sum, m_cnt, m_mode, m_integ, m_lock, m_locked, m_shown;
    int kp, ki;

    function automatic int sgn(input int x);
        return (x >= 0) ? 1 : -1;
    endfunction

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0)
            q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic model_clear(input longint edge_at);
        m_sum = 0; m_cnt = 0; m_integ = 0; m_lock = 0; m_locked = 0;
        while (expq.size() > 0 && expq[$].at >= edge_at)
            void'(expq.pop_back());
    endtask

    task automatic model_sample(input int i, input int q, input longint accept_at);
        int e, avg, out;
        strobe_t s;
        e = sgn(i) * q;
        if (m_mode != 0)
            e = e - sgn(q) * i;
        m_sum += e;
        m_cnt++;
        if (m_cnt == 16) begin
            avg     = floor_div(m_sum, 16);
            m_sum   = 0;
            m_cnt   = 0;
            m_integ = clamp(m_integ + avg, -524287, 524287);
            out     = clamp(avg * (1 << kp) + floor_div(m_integ, 1 << ki), -32768, 32767);
            if (avg < 64 && avg > -64)
                m_lock = (m_lock < 15) ? m_lock + 1 : 15;
            else
                m_lock = (m_lock > 0) ? m_lock - 1 : 0;
            if (m_lock == 15) m_locked = 1;
            if (m_lock == 0)  m_locked = 0;
            s.data = out;
            s.lk   = m_locked;
            s.at   = accept_at + 3;
            expq.push_back(s);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_16M384);
            baseband_valid = 1'b0;
            loop_clear     = 1'b0;
            MODE           = 1'($urandom);
        end
    endtask

    // MODE is only honoured on the first sample of a window; later samples drive noise on it.
    task automatic send(input int i, input int q, input int mode, input bit clr);
        @(negedge clk_16M384);
        baseband_I     = 12'(i);
        baseband_Q     = 12'(q);
        baseband_valid = 1'b1;
        loop_clear     = clr;
        if (m_cnt == 0) begin
            MODE   = 1'(mode);
            m_mode = mode;
        end else begin
            MODE = 1'($urandom);
        end
        if (clr)
            model_clear(cyc + 1);
        else
            model_sample(i, q, cyc + 1);
    endtask

    task automatic send_windows(input int n, input int i, input int q, input int mode);
        repeat (n * 16) send(i, q, mode, 1'b0);
        idle(6);
    endtask

    task automatic pulse_clear();
        @(negedge clk_16M384);
        baseband_valid = 1'b0;
        loop_clear     = 1'b1;
        model_clear(cyc + 1);
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk_16M384);
        rst_16M384     = 1'b1;
        baseband_valid = 1'b0;
        loop_clear     = 1'b0;
        idle(2);
        rst_16M384 = 1'b0;
        model_clear(0);
        m_shown = 0;
        check_eq("reset_tdata", feedback_tdata, 0);
        check_eq("reset_tvalid", feedback_tvalid, 0);
        check_eq("reset_locked", locked, 0);
    endtask

    task automatic set_gains(input int p, input int i);
        kp = p; ki = i;
        KP_SHIFT = 2'(p);
        KI_SHIFT = 4'(i);
    endtask

    always @(negedge clk_16M384) begin
        if (!rst_16M384) begin
            while (expq.size() > 0 && expq[0].at < cyc) begin
                check_eq("strobe_cycle", cyc, expq[0].at);
                void'(expq.pop_front());
            end
            if (feedback_tvalid) begin
                if (expq.size() == 0) begin
                    check_eq("unexpected_strobe", feedback_tvalid, 0);
                end else begin
                    check_eq("strobe_cycle", cyc, expq[0].at);
                    check_eq("tdata", feedback_tdata, expq[0].data);
                    check_eq("locked", locked, expq[0].lk);
                    m_shown = expq[0].data;
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        rst_16M384     = 1'b1;
        baseband_I     = '0;
        baseband_Q     = '0;
        baseband_valid = 1'b0;
        MODE           = 1'b0;
        loop_clear     = 1'b0;
        set_gains(0, 0);
        m_mode = 0;
        model_clear(0);
        m_shown = 0;
        repeat (3) @(negedge clk_16M384);
        check_eq("in_reset_tdata", feedback_tdata, 0);
        check_eq("in_reset_tvalid", feedback_tvalid, 0);
        rst_16M384 = 1'b0;
        check_eq("in_reset_locked", locked, 0);

        // BPSK constant error 200: 400, 600, 800, 1000
        send_windows(4, 1000, 200, 0);
        check_eq("hold_after_bpsk", feedback_tdata, m_shown);

        // QPSK single window: 1443
        do_reset();
        set_gains(1, 4);
        send_windows(1, 1000, -300, 1);
        check_eq("qpsk_out", feedback_tdata, 1443);

        // sgn(0) = +1
        do_reset();
        set_gains(0, 0);
        send_windows(1, 0, -5, 0);
        check_eq("zero_sign_out", feedback_tdata, -10);

        // Lock hysteresis
        do_reset();
        set_gains(0, 15);
        send_windows(15, 1, 10, 0);
        check_eq("lock_set", locked, 1);
        send_windows(14, 1, 500, 0);
        check_eq("lock_held", locked, 1);
        send_windows(1, 1, 500, 0);
        check_eq("lock_dropped", locked, 0);

        // loop_clear with the 10th sample of a window
        do_reset();
        set_gains(0, 0);
        send_windows(1, 1, 100, 0);
        repeat (9) send(1, 100, 0, 1'b0);
        send(1, 100, 0, 1'b1);
        idle(6);
        check_eq("clear_hold_tdata", feedback_tdata, 200);
        check_eq("clear_locked", locked, 0);
        send_windows(1, 1, 100, 0);
        check_eq("after_clear_out", feedback_tdata, 200);

        // loop_clear on the dump edge of a completed window
        repeat (16) send(1, 100, 0, 1'b0);
        idle(1);
        pulse_clear();
        idle(6);
        check_eq("dump_clear_hold", feedback_tdata, 200);
        send_windows(1, 1, 100, 0);
        check_eq("dump_clear_out", feedback_tdata, 200);

        // Integrator and output saturation
        do_reset();
        set_gains(0, 0);
        send_windows(300, 1, 2047, 0);
        check_eq("sat_out", feedback_tdata, 32767);
        set_gains(0, 15);
        send_windows(1, 1, 2047, 0);
        check_eq("sat_integ_probe", feedback_tdata, 2062);

        // Randomized I/Q, mode, gaps and gains
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            set_gains(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            for (int w = 0; w < 10; w++) begin
                int md;
                md = int'($urandom_range(0, 1));
                for (int s = 0; s < 16; s++) begin
                    send(int'($urandom_range(0, 4095)) - 2048,
                         int'($urandom_range(0, 4095)) - 2048, md, 1'b0);
                    if ($urandom_range(0, 3) == 0)
                        idle(int'($urandom_range(1, 3)));
                end
            end
            idle(6);
            if (ph == 1) begin
                repeat (int'($urandom_range(1, 15))) send(300, -700, 1, 1'b0);
                pulse_clear();
                idle(4);
            end
        end

        idle(8);
        check_eq("pending_strobes", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
